// File: rtl/eclair_cs_pkg.sv
// Shared types and constants for the Eclair control-store loader.
package eclair_cs_pkg;
    localparam int CS_ADDR_WIDTH = 8;
    localparam int CS_WORD_WIDTH = 64;
    localparam logic [CS_ADDR_WIDTH-1:0] CS_HALT_ADDR = 8'hFE;

    typedef enum logic [2:0] {
        LOAD_RD = 3'd0,
        LOAD_WR = 3'd1,
        VERIFY  = 3'd2,
        READY   = 3'd3,
        FAIL    = 3'd4
    } cs_state_e;
endpackage

// File: rtl/cs_loader_counter.sv
// Up-counter with synchronous preset, used as the load/verify address.
module cs_loader_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             srst,
    input  logic             inc,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count
);
    logic [WIDTH-1:0] count_r;

    // Count register; preset wins over increment, all-ones wraps to zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {WIDTH{1'b0}};
        end else if (srst) begin
            count_r <= {WIDTH{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (inc) begin
            count_r <= count_r + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;
endmodule

// File: rtl/cs_loader.sv
// Copies the microcode EPROM into the control-store RAM, verifies it, then
// hands the address bus to the sequencer.
module cs_loader
    import eclair_cs_pkg::*;
#(
    parameter int ADDR_WIDTH = CS_ADDR_WIDTH,
    parameter int WORD_WIDTH = CS_WORD_WIDTH,
    parameter int ROM_WAIT   = 1
) (
    input  logic                  clk,
    input  logic                  _reset,
    input  logic                  reload,
    input  logic [ADDR_WIDTH-1:0] seq_addr,
    input  logic [WORD_WIDTH-1:0] rom_data,
    input  logic [WORD_WIDTH-1:0] ram_rdata,
    output logic [ADDR_WIDTH-1:0] cs_addr,
    output logic [WORD_WIDTH-1:0] ram_wdata,
    output logic                  ram__w,
    output logic                  rom__oe,
    output logic                  cs_ready,
    output logic                  load_error,
    output logic [ADDR_WIDTH-1:0] err_addr
);
    cs_state_e             state_r, next_state_s;
    logic [3:0]            wait_cnt_r;
    logic                  wait_last_s;
    logic [ADDR_WIDTH-1:0] addr_s;
    logic                  addr_last_s;
    logic                  cnt_inc_s, cnt_load_s, latch_s, err_set_s, ready_set_s, clear_s;
    logic [WORD_WIDTH-1:0] ram_wdata_r;
    logic                  ram_w_r, rom_oe_r, cs_ready_r, load_error_r;
    logic [ADDR_WIDTH-1:0] err_addr_r;

    cs_loader_counter #(.WIDTH(ADDR_WIDTH)) u_addr (
        .clk      (clk),
        .rst_n    (_reset),
        .srst     (1'b0),
        .inc      (cnt_inc_s),
        .load     (cnt_load_s),
        .load_val ({ADDR_WIDTH{1'b0}}),
        .count    (addr_s)
    );

    assign wait_last_s = (wait_cnt_r == 4'(ROM_WAIT - 1));
    assign addr_last_s = (addr_s == {ADDR_WIDTH{1'b1}});

    // State register
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state_r <= LOAD_RD;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic and per-cycle control strobes
    always_comb begin
        next_state_s = state_r;
        cnt_inc_s    = 1'b0;
        cnt_load_s   = 1'b0;
        latch_s      = 1'b0;
        err_set_s    = 1'b0;
        ready_set_s  = 1'b0;
        clear_s      = 1'b0;
        case (state_r)
            LOAD_RD: begin
                if (wait_last_s) begin
                    next_state_s = LOAD_WR;
                    latch_s      = 1'b1;
                end else begin
                    next_state_s = LOAD_RD;
                end
            end
            LOAD_WR: begin
                if (addr_last_s) begin
                    next_state_s = VERIFY;
                    cnt_load_s   = 1'b1;
                end else begin
                    next_state_s = LOAD_RD;
                    cnt_inc_s    = 1'b1;
                end
            end
            VERIFY: begin
                if (!wait_last_s) begin
                    next_state_s = VERIFY;
                end else if (ram_rdata != rom_data) begin
                    next_state_s = FAIL;
                    err_set_s    = 1'b1;
                end else if (addr_last_s) begin
                    next_state_s = READY;
                    ready_set_s  = 1'b1;
                end else begin
                    cnt_inc_s    = 1'b1;
                end
            end
            READY, FAIL: begin
                if (reload) begin
                    next_state_s = LOAD_RD;
                    cnt_load_s   = 1'b1;
                    clear_s      = 1'b1;
                end else begin
                    next_state_s = state_r;
                end
            end
            default: begin
                next_state_s = LOAD_RD;
                cnt_load_s   = 1'b1;
            end
        endcase
    end

    // Wait counter paces each EPROM access to ROM_WAIT cycles
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            wait_cnt_r <= 4'd0;
        end else if ((state_r == LOAD_RD || state_r == VERIFY) && !wait_last_s) begin
            wait_cnt_r <= wait_cnt_r + 4'd1;
        end else begin
            wait_cnt_r <= 4'd0;
        end
    end

    // Strobes are decoded from the next state so they line up with the state
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            ram_wdata_r  <= {WORD_WIDTH{1'b0}};
            ram_w_r      <= 1'b1;
            rom_oe_r     <= 1'b0;
            cs_ready_r   <= 1'b0;
            load_error_r <= 1'b0;
            err_addr_r   <= {ADDR_WIDTH{1'b0}};
        end else begin
            ram_w_r  <= (next_state_s != LOAD_WR);
            rom_oe_r <= !(next_state_s == LOAD_RD || next_state_s == VERIFY);
            if (latch_s) begin
                ram_wdata_r <= rom_data;
            end
            if (clear_s) begin
                cs_ready_r   <= 1'b0;
                load_error_r <= 1'b0;
                err_addr_r   <= {ADDR_WIDTH{1'b0}};
            end else begin
                if (ready_set_s) begin
                    cs_ready_r <= 1'b1;
                end
                if (err_set_s) begin
                    load_error_r <= 1'b1;
                    err_addr_r   <= addr_s;
                end
            end
        end
    end

    assign cs_addr    = (state_r == READY || state_r == FAIL) ? seq_addr : addr_s;
    assign ram_wdata  = ram_wdata_r;
    assign ram__w     = ram_w_r;
    assign rom__oe    = rom_oe_r;
    assign cs_ready   = cs_ready_r;
    assign load_error = load_error_r;
    assign err_addr   = err_addr_r;
endmodule
